// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback always wins, long-latency
// results wait in a small FIFO and drain in idle slots, with a busy scoreboard.
module rf_wb_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wb_valid,
    input  logic [4:0]               wb_rd,
    input  logic [31:0]              wb_data,
    input  logic                     iss_valid,
    input  logic [4:0]               iss_rd,
    input  logic                     lq_valid,
    output logic                     lq_ready,
    input  logic [4:0]               lq_rd,
    input  logic [31:0]              lq_data,
    output logic                     rf_we,
    output logic [4:0]               rf_waddr,
    output logic [31:0]              rf_wdata,
    output logic [31:0]              busy,
    output logic                     drain_req,
    output logic [$clog2(DEPTH):0]   lq_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [4:0]    r_rd_mem   [DEPTH];
    logic [31:0]   r_data_mem [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [31:0]   r_busy;
    logic [SW-1:0] r_starve;
    logic          r_drain;

    logic          w_active;
    logic          w_nonempty;
    logic          w_deq;
    logic          w_enq;
    logic [4:0]    w_head_rd;
    logic [31:0]   w_busy_next;

    assign w_active   = wb_valid && (wb_rd != 5'd0);
    assign w_nonempty = (r_count != '0);
    assign w_deq      = !w_active && w_nonempty;
    assign lq_ready   = (r_count != CW'(DEPTH));
    // Writes to r0 are accepted so the producer never stalls, but never stored.
    assign w_enq      = lq_valid && lq_ready && (lq_rd != 5'd0);
    assign w_head_rd  = r_rd_mem[r_head];

    assign busy       = r_busy;
    assign drain_req  = r_drain;
    assign lq_count   = r_count;

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        if (w_active) begin
            rf_we    = 1'b1;
            rf_waddr = wb_rd;
            rf_wdata = wb_data;
        end else if (w_nonempty) begin
            rf_we    = 1'b1;
            rf_waddr = w_head_rd;
            rf_wdata = r_data_mem[r_head];
        end
    end

    // Issue is applied after the clear so a same-edge set on that register wins.
    always_comb begin
        w_busy_next = r_busy;
        if (w_deq) begin
            w_busy_next[w_head_rd] = 1'b0;
        end
        if (iss_valid && (iss_rd != 5'd0)) begin
            w_busy_next[iss_rd] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_rd_mem[r_tail]   <= lq_rd;
            r_data_mem[r_tail] <= lq_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_busy   <= '0;
            r_starve <= '0;
            r_drain  <= 1'b0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_deq) begin
                r_head <= r_head + 1'b1;
            end
            if (w_enq && !w_deq) begin
                r_count <= r_count + 1'b1;
            end else if (w_deq && !w_enq) begin
                r_count <= r_count - 1'b1;
            end
            r_busy <= w_busy_next;
            if (!w_nonempty || w_deq) begin
                r_starve <= '0;
            end else if (r_starve != SW'(STARVE_MAX)) begin
                r_starve <= r_starve + 1'b1;
            end
            r_drain <= (r_starve == SW'(STARVE_MAX)) && !w_deq;
        end
    end

endmodule
